program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Host-side front end for the 8-bit stack processor, sitting directly upstream of it and driving its direct memory port, halt and reset pins.
- Streams a length-prefixed program image into processor memory while the processor is halted, then releases the processor for a fixed number of cycles.
- Halts the processor again and streams a window of data memory back out to the host over a valid/ready interface.

Parameters:
- RUN_CYCLES, 256: number of clocks proc_haltN is held high per run (1..65535).
- DUMP_BASE, 8'd128: first data-memory address returned in the dump phase.
- DUMP_LEN, 16: number of bytes returned in the dump phase (1..256).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load/run/dump session.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts in_data this cycle.
- out_valid  output  1  dump byte valid.
- out_data  output  8  dump byte, driven combinationally from proc_read_data.
- out_ready  input  1  host accepts out_data.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE.
- error  output  1  checksum failure (CHECKSUM_EN only; tied 0 otherwise).
- proc_resetN  output  1  to processor resetN.
- proc_haltN  output  1  to processor haltN.
- proc_write_address  output  8  to direct_write_address.
- proc_write_data  output  8  to direct_write_data.
- proc_memory_write  output  1  to direct_memory_write.
- proc_read_address  output  8  to direct_read_address.
- proc_read_data  input  8  from direct_read_data (combinational in processor).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - in_ready=0, out_valid=0, busy=0, done=0, error=0.
  - proc_resetN=1, proc_haltN=0, proc_memory_write=0.
  - All address, data and counter registers = 0.
  - The processor is held halted, and its memory is not cleared by the loader's own reset.
- All proc_* outputs except out_data are registered.
- A byte transfer occurs on a cycle with valid&ready high.
- States:
  - IDLE / DONE:
    - start=1 -> CLEAR; start is ignored in every other state.
    - DONE holds done=1 until start.
  - CLEAR (1 cycle):
    - proc_resetN=0, proc_haltN=0; the processor zeroes its memory and pc.
    - Next state: LEN.
  - LEN:
    - in_ready=1.
    - On transfer: len <= in_data, addr <= 0.
    - If len=0 -> RUN (or CHK if CHECKSUM_EN); else -> LOAD.
  - LOAD:
    - in_ready=1.
    - On transfer, the next cycle asserts proc_memory_write=1 with proc_write_address=addr and proc_write_data=in_data, for exactly one cycle.
    - addr increments by 1 per transfer.
    - After the len-th byte -> RUN (or CHK).
    - proc_haltN=0 throughout, so the direct write is honoured.
    - Back-to-back transfers give one write per cycle.
    - addr wraps 255->0 only if len would exceed 256, which cannot happen (len is at most 255).
  - RUN:
    - in_ready=0, proc_haltN=1 for exactly RUN_CYCLES clocks (16-bit down-counter), then proc_haltN=0 -> DUMP.
    - proc_memory_write=0 while the processor runs.
  - DUMP:
    - proc_read_address = DUMP_BASE + idx (8-bit, wraps modulo 256).
    - out_valid=1, out_data = proc_read_data.
    - idx increments on each out transfer.
    - After DUMP_LEN transfers: out_valid=0 -> DONE.
    - out_data must stay stable while out_valid && !out_ready; this holds because the address only changes on a transfer and the processor is halted.
- Input outside LEN/LOAD/CHK: in_ready=0 and in_valid is ignored.
- Reset mid-session: returns to IDLE next cycle with the reset values above. A half-loaded image stays in processor memory and the processor stays halted.
- The last LOAD write and the entry to RUN never occur in the same cycle: the pending write completes one cycle before proc_haltN rises.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of the length byte plus all payload bytes is accumulated.
  - State CHK follows LOAD, or LEN when len=0, and accepts one extra byte.
  - Byte equals the sum -> RUN.
  - Byte differs -> error=1 and go to DONE with no run and no dump.
  - error clears on the next start or on reset.
- Undefined: no CHK state, no extra byte, and error is constant 0.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then low with no start.
  - Required: proc_haltN=0, proc_resetN=1, in_ready=0, busy=0 for 10 cycles.
- Load path:
  - Stimulus: start, then bytes 0x04,0x01,0x80,0x06,0x81 sent back-to-back.
  - Required: one cycle of proc_resetN=0; writes (0,0x01),(1,0x80),(2,0x06),(3,0x81) on consecutive cycles; proc_haltN rises 1 cycle after the last write.
- Run length and stall:
  - Stimulus: RUN_CYCLES=20.
  - Required: proc_haltN high for exactly 20 clocks.
  - Dump stimulus: DUMP_BASE=0x80, DUMP_LEN=2, processor model storing 0x05,0xFB there, out_ready toggling 1,0,1.
  - Required: out_data=0x05 then 0xFB, held stable while stalled; done=1 afterwards.
- Zero length:
  - Stimulus: len byte 0x00.
  - Required: no proc_memory_write pulse; RUN entered 1 cycle after the len transfer.
- Reset mid-LOAD:
  - Stimulus: reset after 2 of 4 payload bytes.
  - Required: state IDLE, proc_haltN=0, no further writes; a subsequent start runs normally.
- Checksum (CHECKSUM_EN):
  - Stimulus: len 0x02, payload 0x10,0x20, check byte 0x32.
  - Required: run occurs.
  - Stimulus: same image with check byte 0x33.
  - Required: error=1, done=1, proc_haltN never asserted.

Source files
------------

// File: rtl/program_loader.sv
// Host front end for the 8-bit stack processor: loads a length-prefixed image, runs it, dumps a data window.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before the run.
module program_loader #(
    parameter int unsigned RUN_CYCLES = 256,
    parameter logic [7:0]  DUMP_BASE  = 8'd128,
    parameter int unsigned DUMP_LEN   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       proc_resetN,
    output logic       proc_haltN,
    output logic [7:0] proc_write_address,
    output logic [7:0] proc_write_data,
    output logic       proc_memory_write,
    output logic [7:0] proc_read_address,
    input  logic [7:0] proc_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LEN,
        S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [15:0] RUN_INIT  = 16'(RUN_CYCLES);
    localparam logic [7:0]  DUMP_LAST = 8'(DUMP_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        halt_n_q, halt_n_d;
    logic        rst_n_q, rst_n_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        err_q, err_d;
`endif

    logic in_xfer;
    logic out_xfer;

    always_comb begin
        in_ready = (state_q == S_LEN) || (state_q == S_LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (state_q == S_CHK) begin
            in_ready = 1'b1;
        end
`endif
    end

    assign out_valid = (state_q == S_DUMP);
    assign out_data  = proc_read_data;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign proc_resetN        = rst_n_q;
    assign proc_haltN         = halt_n_q;
    assign proc_write_address = wr_addr_q;
    assign proc_write_data    = wr_data_q;
    assign proc_memory_write  = wr_en_q;
    assign proc_read_address  = rd_addr_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        halt_n_d  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: state_d = S_LEN;
            S_LEN: begin
                if (in_xfer) begin
                    len_d  = in_data;
                    addr_d = 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d  = in_data;
                    state_d = (in_data == 8'd0) ? S_CHK : S_LOAD;
`else
                    state_d = (in_data == 8'd0) ? S_RUN : S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (in_xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
                    if (addr_q + 8'd1 == len_q) state_d = S_CHK;
`else
                    if (addr_q + 8'd1 == len_q) state_d = S_RUN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (in_xfer) begin
                    if (in_data == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
`endif
            // First RUN cycle keeps haltN low so the final direct write lands first.
            S_RUN: begin
                if (cnt_q != 16'd0) begin
                    halt_n_d = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                end else begin
                    state_d   = S_DUMP;
                    idx_d     = 8'd0;
                    rd_addr_d = DUMP_BASE;
                end
            end
            S_DUMP: begin
                if (out_xfer) begin
                    if (idx_q == DUMP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        rd_addr_d = DUMP_BASE + idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RUN && state_q != S_RUN) begin
            cnt_d = RUN_INIT;
        end
        rst_n_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= 8'd0;
            addr_q    <= 8'd0;
            cnt_q     <= 16'd0;
            idx_q     <= 8'd0;
            rd_addr_q <= 8'd0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            wr_en_q   <= 1'b0;
            halt_n_q  <= 1'b0;
            rst_n_q   <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            halt_n_q  <= halt_n_d;
            rst_n_q   <= rst_n_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed sessions plus random images against a memory-level reference model.
module tb_program_loader;

    localparam int         RUN_CYC = 20;
    localparam logic [7:0] DBASE   = 8'h80;
    localparam int         DLEN    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy, done, error;
    logic       proc_resetN, proc_haltN, proc_memory_write;
    logic [7:0] proc_write_address, proc_write_data, proc_read_address, proc_read_data;

    program_loader #(.RUN_CYCLES(RUN_CYC), .DUMP_BASE(DBASE), .DUMP_LEN(DLEN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error),
        .proc_resetN(proc_resetN), .proc_haltN(proc_haltN),
        .proc_write_address(proc_write_address), .proc_write_data(proc_write_data),
        .proc_memory_write(proc_memory_write), .proc_read_address(proc_read_address),
        .proc_read_data(proc_read_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Processor memory model and activity capture, all sampled mid-cycle.
    logic [7:0] mem [0:255];
    assign proc_read_data = mem[proc_read_address];

    int         cyc = 0;
    int         rst_low, halt_cnt, halt_rise, last_xfer, wr_run, stall_bad;
    logic       halt_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] wr_a [$];
    logic [7:0] wr_d [$];
    int         wr_c [$];
    logic [7:0] dump_q [$];
    logic [7:0] img [$];
    bit         rdy_rand = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (proc_resetN === 1'b0) begin
            rst_low++;
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        end else begin
            if (proc_memory_write === 1'b1) begin
                if (proc_haltN === 1'b0) mem[proc_write_address] = proc_write_data;
                else wr_run++;
                wr_a.push_back(proc_write_address);
                wr_d.push_back(proc_write_data);
                wr_c.push_back(cyc);
            end
            if (proc_haltN === 1'b1) begin
                halt_cnt++;
                if (halt_prev !== 1'b1) halt_rise = cyc;
                // Toy program semantics: two difference results written into data memory.
                mem[8'h80] = mem[2] - mem[0];
                mem[8'h81] = mem[0] - mem[2];
            end
        end
        halt_prev = proc_haltN;
        if (in_valid && in_ready) last_xfer = cyc;
        if (out_valid && out_ready) dump_q.push_back(out_data);
        if (stall_prev && out_valid && (out_data !== stall_data)) stall_bad++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : ~out_ready;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        rst_low = 0; halt_cnt = 0; halt_rise = -1; last_xfer = -1; wr_run = 0; stall_bad = 0;
        wr_a.delete(); wr_d.delete(); wr_c.delete(); dump_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk1("in_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk1("clear_resetN", proc_resetN, 1'b0);
        chk1("clear_error", error, 1'b0);
    endtask

    task automatic session(input bit corrupt_in, input bit gaps);
        int         len;
        int         k;
        bit         corrupt;
        logic [7:0] sum;
        logic [7:0] m [0:255];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        corrupt = corrupt_in;
`else
        corrupt = 1'b0;
        if (corrupt_in) corrupt = 1'b0;
`endif
        len = img.size();
        sum = 8'(len);
        foreach (img[i]) sum = sum + img[i];
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        foreach (img[i]) m[i] = img[i];
        if (!corrupt) begin
            m[8'h80] = m[2] - m[0];
            m[8'h81] = m[0] - m[2];
        end

        clr_mon();
        start_pulse();
        send_byte(8'(len), gaps);
        foreach (img[i]) send_byte(img[i], gaps);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(corrupt ? sum + 8'd1 : sum, gaps);
`endif
        if (gaps) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        in_valid = 1'b0;
        chk1("done", done, 1'b1);
        chk1("busy_after", busy, 1'b0);
        chk1("error", error, corrupt);
        chk32("resetN_low_cycles", rst_low, 1);
        chk32("write_count", wr_a.size(), len);
        for (int i = 0; i < len && i < wr_a.size(); i++) begin
            chk8("write_addr", wr_a[i], 8'(i));
            chk8("write_data", wr_d[i], img[i]);
            if (!gaps && i > 0) chk32("write_consecutive", wr_c[i], wr_c[i-1] + 1);
        end
        chk32("write_while_running", wr_run, 0);
        chk32("halt_cycles", halt_cnt, corrupt ? 0 : RUN_CYC);
        if (!corrupt) chk32("halt_rise_cycle", halt_rise, last_xfer + 2);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        if (len > 0 && wr_c.size() > 0) chk32("halt_after_last_write", halt_rise, wr_c[wr_c.size()-1] + 1);
`endif
        chk32("dump_count", dump_q.size(), corrupt ? 0 : DLEN);
        for (int j = 0; j < dump_q.size() && j < DLEN; j++)
            chk8("dump_data", dump_q[j], m[8'(DBASE + 8'(j))]);
        chk32("dump_stall_stable", stall_bad, 0);
    endtask

    initial begin
        clr_mon();
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_mem_write", proc_memory_write, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk1("idle_haltN", proc_haltN, 1'b0);
            chk1("idle_resetN", proc_resetN, 1'b1);
            chk1("idle_in_ready", in_ready, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            @(negedge clk);
        end

        // Reference program: dump must return 0x05, 0xFB.
        img = '{8'h01, 8'h80, 8'h06, 8'h81};
        session(1'b0, 1'b0);
        chk8("directed_dump0", dump_q.size() > 0 ? dump_q[0] : 8'hxx, 8'h05);
        chk8("directed_dump1", dump_q.size() > 1 ? dump_q[1] : 8'hxx, 8'hFB);

        img.delete();
        session(1'b0, 1'b0);

        // Reset part-way through a four-byte load.
        clr_mon();
        start_pulse();
        send_byte(8'd4, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk1("midreset_busy", busy, 1'b0);
        chk1("midreset_haltN", proc_haltN, 1'b0);
        chk1("midreset_in_ready", in_ready, 1'b0);
        repeat (10) @(negedge clk);
        chk32("midreset_writes", wr_a.size(), 2);
        chk32("midreset_halt", halt_cnt, 0);

        img = '{8'h01, 8'h80, 8'h06, 8'h81};
        session(1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img = '{8'h10, 8'h20};
        session(1'b0, 1'b0);
        session(1'b1, 1'b0);
        session(1'b0, 1'b0);
`endif

        rdy_rand = 1'b1;
        for (int s = 0; s < 16; s++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(130, 200) : $urandom_range(0, 8);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            session($urandom_range(0, 3) == 0, s[0]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
